// File: rtl/hamming74_serial_rx_if.sv
// ---------------------------------------------------------------------------
// hamming74_serial_rx_if
//   Channel-side bundle of the serial Hamming(7,4) receiver.
//   master : channel source / consumer (drives frame_start, serial_in)
//   slave  : the receiver (drives decoded results and the re-serialised data)
//
//   frame_start  : high with codeword position 1
//   serial_in    : one channel bit per cycle
//   data_out     : decoded {d1,d2,d3,d4}, d1 at bit 3
//   data_valid   : one-cycle pulse when data_out/syndrome/err_flag update
//   syndrome     : {s4,s2,s1} of the last frame
//   err_flag     : syndrome != 0 for the last frame
//   serial_out   : re-serialised data bits
//   serial_valid : high while serial_out carries a data bit
//   frame_abort  : one-cycle pulse when a partial frame was discarded
// ---------------------------------------------------------------------------
interface hamming74_serial_rx_if;
    logic       frame_start;
    logic       serial_in;
    logic [3:0] data_out;
    logic       data_valid;
    logic [2:0] syndrome;
    logic       err_flag;
    logic       serial_out;
    logic       serial_valid;
    logic       frame_abort;

    modport master (
        output frame_start, serial_in,
        input  data_out, data_valid, syndrome, err_flag,
               serial_out, serial_valid, frame_abort
    );

    modport slave (
        input  frame_start, serial_in,
        output data_out, data_valid, syndrome, err_flag,
               serial_out, serial_valid, frame_abort
    );
endinterface

// File: rtl/hamming74_serial_rx.sv
// ---------------------------------------------------------------------------
// hamming74_serial_rx
//   Deserialises one 7-bit Hamming(7,4) codeword per frame (position 1
//   first, order p1 p2 d1 p4 d2 d3 d4), computes the syndrome, optionally
//   corrects the addressed bit, presents the 4 data bits in parallel and
//   shifts them out again on serial_out over the following 4 cycles.
//
//   Parameters
//     EN_CORRECT    : 1 = flip the bit addressed by the syndrome
//     MSB_FIRST_OUT : 1 = serial_out starts with data_out[3]
//
//   Ports
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     rx    : channel bundle (slave side), see hamming74_serial_rx_if
// ---------------------------------------------------------------------------
module hamming74_serial_rx #(
    parameter bit EN_CORRECT    = 1'b1,
    parameter bit MSB_FIRST_OUT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hamming74_serial_rx_if.slave    rx
);

    localparam int SER_BITS = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;       // bits of the current frame already held
    logic [5:0]    sh, sh_nxt;         // c1..c6, c1 ends up at bit 5
    logic          done, abort;

    // Decode path (combinational, evaluated in the cycle carrying c7)
    logic [6:0]    code;               // c1 at bit 6 .. c7 at bit 0
    logic [7:1]    c, cc;              // indexed by codeword position
    logic [2:0]    syn;
    logic [3:0]    dec;
    logic [3:0]    ser_load;

    // Output registers
    logic [3:0]          data_q;
    logic                dv_q;
    logic [2:0]          syn_q;
    logic                err_q;
    logic                abort_q;
    logic [SER_BITS-1:0] ser_sh;
    logic [SER_BITS-1:0] vld_pipe;

    // ------------------------------------------------------------------
    // Receive FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
            sh    <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sh    <= sh_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM: next state. A frame_start while shifting restarts the
    // frame with the current bit as c1, including the cycle that would
    // otherwise carry c7.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sh_nxt    = sh;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (rx.frame_start) begin
                    sh_nxt    = {5'd0, rx.serial_in};
                    cnt_nxt   = 3'd1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (rx.frame_start) begin
                    abort   = 1'b1;
                    sh_nxt  = {5'd0, rx.serial_in};
                    cnt_nxt = 3'd1;
                end else if (cnt == 3'd6) begin
                    // serial_in is c7: the frame is complete this cycle
                    done      = 1'b1;
                    sh_nxt    = 6'd0;
                    cnt_nxt   = 3'd0;
                    state_nxt = IDLE;
                end else begin
                    sh_nxt  = {sh[4:0], rx.serial_in};
                    cnt_nxt = cnt + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Syndrome and correction on the complete codeword {c1..c6, c7}
    // ------------------------------------------------------------------
    assign code = {sh, rx.serial_in};
    assign c    = {code[0], code[1], code[2], code[3], code[4], code[5], code[6]};

    assign syn[0] = c[1] ^ c[3] ^ c[5] ^ c[7];
    assign syn[1] = c[2] ^ c[3] ^ c[6] ^ c[7];
    assign syn[2] = c[4] ^ c[5] ^ c[6] ^ c[7];

    // A parity-position syndrome flips a parity bit only, so data is
    // unaffected while err_flag still reports the hit.
    always_comb begin
        cc = c;
        for (int i = 1; i <= 7; i++) begin
            cc[i] = c[i] ^ (EN_CORRECT && (syn == 3'(i)));
        end
    end

    assign dec      = {cc[3], cc[5], cc[6], cc[7]};
    assign ser_load = MSB_FIRST_OUT ? dec : {dec[0], dec[1], dec[2], dec[3]};

    // ------------------------------------------------------------------
    // Output registers. The shifter is loaded with the first bit already
    // on top, so serial_out carries data in the same cycle as data_valid.
    // Zeros shift in behind, which keeps serial_out low once drained.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= 4'd0;
            dv_q     <= 1'b0;
            syn_q    <= 3'd0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
            ser_sh   <= '0;
            vld_pipe <= '0;
        end else begin
            dv_q    <= done;
            abort_q <= abort;
            if (done) begin
                data_q   <= dec;
                syn_q    <= syn;
                err_q    <= |syn;
                ser_sh   <= ser_load;
                vld_pipe <= '1;
            end else begin
                ser_sh   <= {ser_sh[SER_BITS-2:0], 1'b0};
                vld_pipe <= {vld_pipe[SER_BITS-2:0], 1'b0};
            end
        end
    end

    assign rx.data_out     = data_q;
    assign rx.data_valid   = dv_q;
    assign rx.syndrome     = syn_q;
    assign rx.err_flag     = err_q;
    assign rx.frame_abort  = abort_q;
    assign rx.serial_out   = ser_sh[SER_BITS-1];
    assign rx.serial_valid = vld_pipe[SER_BITS-1];

endmodule

// File: tb/tb_hamming74_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_hamming74_serial_rx
//   Two receivers share one channel: dut_a corrects and sends MSB first,
//   dut_b only detects and sends LSB first. A frame-level reference model
//   (bit queue per frame, syndrome as XOR of the set-bit positions) predicts
//   every output of both receivers after every clock edge.
// ---------------------------------------------------------------------------
module tb_hamming74_serial_rx;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hamming74_serial_rx_if ifa ();
    hamming74_serial_rx_if ifb ();

    hamming74_serial_rx #(.EN_CORRECT(1'b1), .MSB_FIRST_OUT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(ifa)
    );
    hamming74_serial_rx #(.EN_CORRECT(1'b0), .MSB_FIRST_OUT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(ifb)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic       bits_q[$];
    bit         active = 1'b0;
    logic [3:0] ea_data = 4'd0, eb_data = 4'd0;
    logic [2:0] e_syn   = 3'd0;
    logic       e_err   = 1'b0;
    logic       sa_q[$];
    logic       sb_q[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Data goes to positions 3,5,6,7; parity bit p covers every data
    // position whose index has bit p set.
    function automatic logic [7:1] encode(input logic [3:0] d);
        logic [7:1] c;
        c    = '0;
        c[3] = d[3];
        c[5] = d[2];
        c[6] = d[1];
        c[7] = d[0];
        for (int p = 1; p <= 4; p = p * 2)
            for (int j = 3; j <= 7; j++)
                if (j != 4 && (j & p) != 0) c[p] = c[p] ^ c[j];
        return c;
    endfunction

    // Vector written position 1 first (leftmost char = c1)
    function automatic logic [7:1] p1first(input logic [6:0] v);
        logic [7:1] c;
        for (int i = 1; i <= 7; i++) c[i] = v[7-i];
        return c;
    endfunction

    function automatic logic [2:0] refsyn(input logic [7:1] c);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 1; i <= 7; i++) if (c[i]) s = s ^ 3'(i);
        return s;
    endfunction

    task automatic chk_outputs(input string tag, input logic dv, input logic ab,
                               input logic sa, input logic sav, input logic sb, input logic sbv);
        chk({tag, ".dv_a"},   8'(ifa.data_valid),   8'(dv));
        chk({tag, ".ab_a"},   8'(ifa.frame_abort),  8'(ab));
        chk({tag, ".data_a"}, 8'(ifa.data_out),     8'(ea_data));
        chk({tag, ".syn_a"},  8'(ifa.syndrome),     8'(e_syn));
        chk({tag, ".err_a"},  8'(ifa.err_flag),     8'(e_err));
        chk({tag, ".so_a"},   8'(ifa.serial_out),   8'(sa));
        chk({tag, ".sv_a"},   8'(ifa.serial_valid), 8'(sav));
        chk({tag, ".dv_b"},   8'(ifb.data_valid),   8'(dv));
        chk({tag, ".ab_b"},   8'(ifb.frame_abort),  8'(ab));
        chk({tag, ".data_b"}, 8'(ifb.data_out),     8'(eb_data));
        chk({tag, ".syn_b"},  8'(ifb.syndrome),     8'(e_syn));
        chk({tag, ".err_b"},  8'(ifb.err_flag),     8'(e_err));
        chk({tag, ".so_b"},   8'(ifb.serial_out),   8'(sb));
        chk({tag, ".sv_b"},   8'(ifb.serial_valid), 8'(sbv));
    endtask

    // One channel cycle: drive, clock, advance the model, compare.
    task automatic cyc(input bit fs, input bit b);
        logic       dv, ab, sa, sav, sb, sbv;
        logic [7:1] c, ca;
        ifa.frame_start = fs; ifa.serial_in = b;
        ifb.frame_start = fs; ifb.serial_in = b;
        @(posedge clk);
        #1;
        dv = 1'b0;
        ab = 1'b0;
        if (fs) begin
            ab = active;
            bits_q.delete();
            bits_q.push_back(b);
            active = 1'b1;
        end else if (active) begin
            bits_q.push_back(b);
            if (bits_q.size() == 7) begin
                for (int i = 1; i <= 7; i++) c[i] = bits_q[i-1];
                e_syn = refsyn(c);
                e_err = (e_syn != 3'd0);
                ca    = c;
                if (e_err) ca[e_syn] = ~ca[e_syn];
                ea_data = {ca[3], ca[5], ca[6], ca[7]};
                eb_data = {c[3], c[5], c[6], c[7]};
                for (int i = 3; i >= 0; i--) sa_q.push_back(ea_data[i]);
                for (int i = 0; i <= 3; i++) sb_q.push_back(eb_data[i]);
                dv     = 1'b1;
                active = 1'b0;
                bits_q.delete();
            end
        end
        if (sa_q.size() > 0) begin sa = sa_q.pop_front(); sav = 1'b1; end
        else begin sa = 1'b0; sav = 1'b0; end
        if (sb_q.size() > 0) begin sb = sb_q.pop_front(); sbv = 1'b1; end
        else begin sb = 1'b0; sbv = 1'b0; end
        chk_outputs("cyc", dv, ab, sa, sav, sb, sbv);
    endtask

    task automatic send_code(input logic [7:1] c);
        for (int i = 1; i <= 7; i++) cyc(i == 1, c[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom));
    endtask

    // Asynchronous reset asserted between edges, outputs must clear at once.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        active = 1'b0;
        bits_q.delete();
        sa_q.delete();
        sb_q.delete();
        ea_data = 4'd0; eb_data = 4'd0; e_syn = 3'd0; e_err = 1'b0;
        chk_outputs(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ifa.frame_start = 1'b0; ifb.frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs({tag, "_hold"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:1] c;
        logic [3:0] d;
        int         mode, p1, p2, nb;

        ifa.frame_start = 1'b0; ifa.serial_in = 1'b0;
        ifb.frame_start = 1'b0; ifb.serial_in = 1'b0;
        #1;
        async_reset("reset");
        idle(5);

        // Clean frame 1011 -> 0110011
        send_code(p1first(7'b0110011));
        chk("clean.data", 8'(ifa.data_out), 8'h0B);
        chk("clean.syn",  8'(ifa.syndrome), 8'h00);
        chk("clean.err",  8'(ifa.err_flag), 8'h00);
        idle(5);

        // Data error at position 5
        send_code(p1first(7'b0110111));
        chk("d5.data_a", 8'(ifa.data_out), 8'h0B);
        chk("d5.syn_a",  8'(ifa.syndrome), 8'h05);
        chk("d5.err_a",  8'(ifa.err_flag), 8'h01);
        chk("d5.data_b", 8'(ifb.data_out), 8'h0F);
        chk("d5.syn_b",  8'(ifb.syndrome), 8'h05);
        idle(5);

        // Parity error at position 1
        send_code(p1first(7'b1110011));
        chk("p1.data_a", 8'(ifa.data_out), 8'h0B);
        chk("p1.syn_a",  8'(ifa.syndrome), 8'h01);
        chk("p1.err_a",  8'(ifa.err_flag), 8'h01);
        idle(5);

        // Abort after 3 bits, then clean 0101
        cyc(1'b1, 1'b1); cyc(1'b0, 1'b0); cyc(1'b0, 1'b1);
        send_code(encode(4'b0101));
        chk("abort.data", 8'(ifa.data_out), 8'h05);
        idle(5);

        // Back-to-back, zero gap
        send_code(encode(4'b1011));
        send_code(encode(4'b0110));
        chk("b2b.data", 8'(ifa.data_out), 8'h06);
        idle(6);

        // frame_start coincident with c7 aborts the frame
        c = encode(4'b1100);
        for (int i = 1; i <= 6; i++) cyc(i == 1, c[i]);
        send_code(encode(4'b0011));
        chk("abort7.data", 8'(ifa.data_out), 8'h03);
        idle(5);

        // Reset mid-output
        send_code(encode(4'b1001));
        cyc(1'b0, 1'b0);
        async_reset("rst_out");
        idle(6);

        // Reset at position 4, then the rest of the old frame must be ignored
        c = encode(4'b0111);
        for (int i = 1; i <= 3; i++) cyc(i == 1, c[i]);
        ifa.frame_start = 1'b0; ifa.serial_in = c[4];
        ifb.frame_start = 1'b0; ifb.serial_in = c[4];
        async_reset("rst_pos4");
        for (int i = 5; i <= 7; i++) cyc(1'b0, c[i]);
        idle(4);
        send_code(encode(4'b1110));
        chk("post_rst.data", 8'(ifa.data_out), 8'h0E);
        idle(4);

        // Randomised frames: clean, single, double error, aborted prefix
        for (int t = 0; t < 60; t++) begin
            d    = 4'($urandom);
            c    = encode(d);
            mode = $urandom_range(0, 3);
            if (mode == 1) begin
                p1 = $urandom_range(1, 7);
                c[p1] = ~c[p1];
            end else if (mode == 2) begin
                p1 = $urandom_range(1, 7);
                p2 = (p1 % 7) + $urandom_range(1, 6);
                if (p2 > 7) p2 = p2 - 7;
                c[p1] = ~c[p1];
                c[p2] = ~c[p2];
            end else if (mode == 3) begin
                nb = $urandom_range(1, 6);
                for (int i = 0; i < nb; i++) cyc(i == 0, 1'($urandom));
            end
            send_code(c);
            idle($urandom_range(0, 3));
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
